rtp_audio_rx: RTL and testbench

Receive-side counterpart of the RTP audio packetizer. Consumes the UDP receive byte stream, validates the 12-byte RTP header (fixed first header word and SSRC), tracks sequence continuity, and unpacks the big-endian signed 16-bit payload samples into an internal sample FIFO. The audio output path drains the FIFO one sample per `wav_rden` strobe.

---
 rtl/rtp_audio_rx.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_rtp_audio_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rtp_audio_rx.sv
// rtp_audio_rx: receive side of the RTP audio link.
// Parses the UDP byte stream, validates the fixed RTP header word and SSRC,
// tracks sequence continuity and unpacks big-endian 16-bit samples into a
// sample FIFO that the audio output path drains one word per wav_rden.
module rtp_audio_rx #(
    parameter logic [15:0] RTP_Header_Param = 16'h8080,
    parameter logic [31:0] SSRC             = 32'h12345678,
    parameter int          FIFO_DEPTH       = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          udp_rec_data_valid,
    input  logic [7:0]                    udp_rec_rdata,
    input  logic [15:0]                   udp_rec_data_length,
    input  logic                          wav_rden,
    output logic [15:0]                   wav_out_data,
    output logic                          wav_underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   rx_seq,
    output logic [31:0]                   rx_timestamp,
    output logic [15:0]                   pkt_cnt,
    output logic [15:0]                   drop_cnt,
    output logic [15:0]                   lost_cnt,
    output logic [15:0]                   ovf_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // Expected value of a checked header byte (bytes 0-1 and 8-11).
    function automatic logic [7:0] hdr_expect(input logic [3:0] idx);
        case (idx)
            4'd0:    return RTP_Header_Param[15:8];
            4'd1:    return RTP_Header_Param[7:0];
            4'd8:    return SSRC[31:24];
            4'd9:    return SSRC[23:16];
            4'd10:   return SSRC[15:8];
            4'd11:   return SSRC[7:0];
            default: return 8'h00;
        endcase
    endfunction

    // True for header bytes whose value is fixed and must match.
    function automatic logic hdr_checked(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd8, 4'd9, 4'd10, 4'd11: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [15:0]     bcnt_q, bcnt_d;
    logic [15:0]     len_q, len_d;
    logic            err_q, err_d;
    logic [15:0]     seq_tmp_q, seq_tmp_d;
    logic [31:0]     ts_tmp_q, ts_tmp_d;
    logic [7:0]      hi_q, hi_d;
    logic [15:0]     exp_seq_q, exp_seq_d;
    logic            seq_valid_q, seq_valid_d;
    logic [15:0]     rx_seq_q, rx_seq_d;
    logic [31:0]     rx_ts_q, rx_ts_d;
    logic [15:0]     pkt_cnt_q, pkt_cnt_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic [15:0]     lost_cnt_q, lost_cnt_d;
    logic [15:0]     ovf_cnt_q, ovf_cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [15:0]     wav_out_q, wav_out_d;
    logic            underrun_q, underrun_d;
    logic [15:0]     mem_q [FIFO_DEPTH];

    logic            wr_en_s;
    logic [15:0]     wr_data_s;
    logic            err_now_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            do_wr_s;
    logic            do_rd_s;

    // Packet parser: next state, header capture and packet/drop/loss counters.
    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        len_d       = len_q;
        err_d       = err_q;
        seq_tmp_d   = seq_tmp_q;
        ts_tmp_d    = ts_tmp_q;
        hi_d        = hi_q;
        exp_seq_d   = exp_seq_q;
        seq_valid_d = seq_valid_q;
        rx_seq_d    = rx_seq_q;
        rx_ts_d     = rx_ts_q;
        pkt_cnt_d   = pkt_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        lost_cnt_d  = lost_cnt_q;
        wr_en_s     = 1'b0;
        wr_data_s   = {hi_q, udp_rec_rdata};
        err_now_s   = err_q | (hdr_checked(bcnt_q[3:0]) &&
                               (udp_rec_rdata != hdr_expect(bcnt_q[3:0])));

        case (state_q)
            ST_IDLE: begin
                if (udp_rec_data_valid) begin
                    len_d  = udp_rec_data_length;
                    bcnt_d = 16'd1;
                    err_d  = (udp_rec_rdata != hdr_expect(4'd0));
                    if (udp_rec_data_length < 16'd12) begin
                        state_d    = ST_DISCARD;
                        drop_cnt_d = sat_inc(drop_cnt_q);
                    end else begin
                        state_d = ST_HEADER;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_HEADER: begin
                if (udp_rec_data_valid) begin
                    bcnt_d = bcnt_q + 16'd1;
                    err_d  = err_now_s;
                    case (bcnt_q[3:0])
                        4'd2:                     seq_tmp_d = {udp_rec_rdata, seq_tmp_q[7:0]};
                        4'd3:                     seq_tmp_d = {seq_tmp_q[15:8], udp_rec_rdata};
                        4'd4, 4'd5, 4'd6, 4'd7:   ts_tmp_d  = {ts_tmp_q[23:0], udp_rec_rdata};
                        default:                  ts_tmp_d  = ts_tmp_q;
                    endcase
                    if (bcnt_q == 16'd11) begin
                        if (err_now_s) begin
                            state_d    = ST_DISCARD;
                            drop_cnt_d = sat_inc(drop_cnt_q);
                        end else begin
                            pkt_cnt_d = sat_inc(pkt_cnt_q);
                            rx_seq_d  = seq_tmp_q;
                            rx_ts_d   = ts_tmp_q;
                            if (seq_valid_q && (seq_tmp_q != exp_seq_q)) begin
                                lost_cnt_d = sat_inc(lost_cnt_q);
                            end else begin
                                lost_cnt_d = lost_cnt_q;
                            end
                            exp_seq_d   = seq_tmp_q + 16'd1;
                            seq_valid_d = 1'b1;
                            // A header-only packet ends here; DISCARD waits out the gap.
                            state_d     = (len_q == 16'd12) ? ST_DISCARD : ST_PAYLOAD;
                        end
                    end else begin
                        state_d = ST_HEADER;
                    end
                end else begin
                    state_d    = ST_IDLE;
                    drop_cnt_d = sat_inc(drop_cnt_q);
                end
            end

            ST_PAYLOAD: begin
                if (udp_rec_data_valid) begin
                    bcnt_d = bcnt_q + 16'd1;
                    // Payload starts at an even index, so bit 0 selects hi/lo byte.
                    if (!bcnt_q[0]) begin
                        hi_d = udp_rec_rdata;
                    end else begin
                        wr_en_s = 1'b1;
                    end
                    if (bcnt_q == (len_q - 16'd1)) begin
                        state_d = ST_DISCARD;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                    hi_d    = 8'h00;
                end
            end

            ST_DISCARD: begin
                if (!udp_rec_data_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DISCARD;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sample FIFO bookkeeping and registered read port; reads see pre-write state.
    always_comb begin
        fifo_full_s  = (level_q == LW'(FIFO_DEPTH));
        fifo_empty_s = (level_q == {LW{1'b0}});
        do_wr_s      = wr_en_s && !fifo_full_s;
        do_rd_s      = wav_rden && !fifo_empty_s;
        wr_ptr_d     = do_wr_s ? (wr_ptr_q + {{(AW-1){1'b0}}, 1'b1}) : wr_ptr_q;
        rd_ptr_d     = do_rd_s ? (rd_ptr_q + {{(AW-1){1'b0}}, 1'b1}) : rd_ptr_q;
        level_d      = level_q + {{AW{1'b0}}, do_wr_s} - {{AW{1'b0}}, do_rd_s};
        if (wr_en_s && fifo_full_s) begin
            ovf_cnt_d = sat_inc(ovf_cnt_q);
        end else begin
            ovf_cnt_d = ovf_cnt_q;
        end
        if (wav_rden) begin
            wav_out_d  = fifo_empty_s ? 16'h0000 : mem_q[rd_ptr_q];
            underrun_d = fifo_empty_s;
        end else begin
            wav_out_d  = wav_out_q;
            underrun_d = 1'b0;
        end
    end

    // Sample storage; no reset needed since occupancy is tracked by level_q.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q] <= wr_data_s;
        end
    end

    // State, header, counter and FIFO pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bcnt_q      <= 16'd0;
            len_q       <= 16'd0;
            err_q       <= 1'b0;
            seq_tmp_q   <= 16'd0;
            ts_tmp_q    <= 32'd0;
            hi_q        <= 8'h00;
            exp_seq_q   <= 16'd0;
            seq_valid_q <= 1'b0;
            rx_seq_q    <= 16'd0;
            rx_ts_q     <= 32'd0;
            pkt_cnt_q   <= 16'd0;
            drop_cnt_q  <= 16'd0;
            lost_cnt_q  <= 16'd0;
            ovf_cnt_q   <= 16'd0;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            level_q     <= {LW{1'b0}};
            wav_out_q   <= 16'h0000;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            len_q       <= len_d;
            err_q       <= err_d;
            seq_tmp_q   <= seq_tmp_d;
            ts_tmp_q    <= ts_tmp_d;
            hi_q        <= hi_d;
            exp_seq_q   <= exp_seq_d;
            seq_valid_q <= seq_valid_d;
            rx_seq_q    <= rx_seq_d;
            rx_ts_q     <= rx_ts_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            lost_cnt_q  <= lost_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            wav_out_q   <= wav_out_d;
            underrun_q  <= underrun_d;
        end
    end

    assign wav_out_data = wav_out_q;
    assign wav_underrun = underrun_q;
    assign fifo_level   = level_q;
    assign rx_seq       = rx_seq_q;
    assign rx_timestamp = rx_ts_q;
    assign pkt_cnt      = pkt_cnt_q;
    assign drop_cnt     = drop_cnt_q;
    assign lost_cnt     = lost_cnt_q;
    assign ovf_cnt      = ovf_cnt_q;

endmodule

// File: tb/tb_rtp_audio_rx.sv
// tb_rtp_audio_rx: directed-vector bench for rtp_audio_rx (FIFO depth 4).
module tb_rtp_audio_rx;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [7:0]  rdata;
    logic [15:0] dlen;
    logic        rden;
    logic [15:0] wav_out_data;
    logic        wav_underrun;
    logic [2:0]  fifo_level;
    logic [15:0] rx_seq;
    logic [31:0] rx_timestamp;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;
    logic [15:0] lost_cnt;
    logic [15:0] ovf_cnt;

    int          n_tests;
    int          n_fail;
    logic [7:0]  pb [0:63];

    rtp_audio_rx #(
        .RTP_Header_Param (16'h8080),
        .SSRC             (32'h12345678),
        .FIFO_DEPTH       (4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .udp_rec_data_valid  (valid),
        .udp_rec_rdata       (rdata),
        .udp_rec_data_length (dlen),
        .wav_rden            (rden),
        .wav_out_data        (wav_out_data),
        .wav_underrun        (wav_underrun),
        .fifo_level          (fifo_level),
        .rx_seq              (rx_seq),
        .rx_timestamp        (rx_timestamp),
        .pkt_cnt             (pkt_cnt),
        .drop_cnt            (drop_cnt),
        .lost_cnt            (lost_cnt),
        .ovf_cnt             (ovf_cnt)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put_hdr(input logic [15:0] p, input logic [15:0] seq,
                           input logic [31:0] ts, input logic [31:0] ssrc);
        pb[0]  = p[15:8];    pb[1]  = p[7:0];
        pb[2]  = seq[15:8];  pb[3]  = seq[7:0];
        pb[4]  = ts[31:24];  pb[5]  = ts[23:16];  pb[6]  = ts[15:8];  pb[7]  = ts[7:0];
        pb[8]  = ssrc[31:24]; pb[9] = ssrc[23:16]; pb[10] = ssrc[15:8]; pb[11] = ssrc[7:0];
    endtask

    task automatic put_word(input int idx, input logic [15:0] w);
        pb[12 + 2*idx]     = w[15:8];
        pb[12 + 2*idx + 1] = w[7:0];
    endtask

    // Drive nbytes of pb[] back to back, then a gap of idle cycles.
    task automatic send(input int nbytes, input logic [15:0] len);
        for (int i = 0; i < nbytes; i++) begin
            @(posedge clk); #1;
            valid = 1'b1;
            rdata = pb[i];
            dlen  = len;
        end
        @(posedge clk); #1;
        valid = 1'b0;
        rdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [15:0] exp_d, input logic exp_u);
        @(posedge clk); #1;
        rden = 1'b1;
        @(posedge clk); #1;
        rden = 1'b0;
        check({tag, "_data"}, {16'h0, wav_out_data}, {16'h0, exp_d});
        check({tag, "_unr"}, {31'h0, wav_underrun}, {31'h0, exp_u});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        valid   = 1'b0;
        rdata   = 8'h00;
        dlen    = 16'd0;
        rden    = 1'b0;
        for (int i = 0; i < 64; i++) pb[i] = 8'h00;

        // Power-on reset values
        #2;
        check("rst_pkt",   {16'h0, pkt_cnt},  32'h0);
        check("rst_level", {29'h0, fifo_level}, 32'h0);
        check("rst_unr",   {31'h0, wav_underrun}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Valid packet with three samples
        put_hdr(16'h8080, 16'h0005, 32'h00000010, 32'h12345678);
        put_word(0, 16'h0001); put_word(1, 16'hFFFE); put_word(2, 16'h8000);
        send(18, 16'd18);
        check("v_pkt",   {16'h0, pkt_cnt}, 32'd1);
        check("v_seq",   {16'h0, rx_seq}, 32'd5);
        check("v_ts",    rx_timestamp, 32'd16);
        check("v_level", {29'h0, fifo_level}, 32'd3);
        rd("v_rd0", 16'h0001, 1'b0);
        rd("v_rd1", 16'hFFFE, 1'b0);
        rd("v_rd2", 16'h8000, 1'b0);
        rd("v_rd3", 16'h0000, 1'b1);
        @(posedge clk); #1;
        check("v_unr_pulse", {31'h0, wav_underrun}, 32'd0);

        // Header rejections: wrong SSRC, then a too-short packet
        put_hdr(16'h8080, 16'h0006, 32'h00000020, 32'h12345679);
        put_word(0, 16'h1111); put_word(1, 16'h2222);
        send(16, 16'd16);
        put_hdr(16'h8080, 16'h0006, 32'h00000020, 32'h12345678);
        send(8, 16'd8);
        check("rej_drop",  {16'h0, drop_cnt}, 32'd2);
        check("rej_level", {29'h0, fifo_level}, 32'd0);
        check("rej_pkt",   {16'h0, pkt_cnt}, 32'd1);

        // Reset in the middle of a packet
        put_hdr(16'h8080, 16'h0007, 32'h00000030, 32'h12345678);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            valid = 1'b1;
            rdata = pb[i];
            dlen  = 16'd20;
        end
        @(posedge clk); #1;
        rst   = 1'b1;
        valid = 1'b0;
        #1;
        check("mrst_pkt",  {16'h0, pkt_cnt}, 32'd0);
        check("mrst_drop", {16'h0, drop_cnt}, 32'd0);
        check("mrst_seq",  {16'h0, rx_seq}, 32'd0);
        check("mrst_ts",   rx_timestamp, 32'd0);
        check("mrst_data", {16'h0, wav_out_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Sequence tracking across the 16-bit wrap
        put_hdr(16'h8080, 16'hFFFF, 32'hA0000001, 32'h12345678);
        send(12, 16'd12);
        put_hdr(16'h8080, 16'h0000, 32'hA0000002, 32'h12345678);
        send(12, 16'd12);
        check("seq_wrap_lost", {16'h0, lost_cnt}, 32'd0);
        put_hdr(16'h8080, 16'h0002, 32'hA0000003, 32'h12345678);
        send(12, 16'd12);
        check("seq_lost", {16'h0, lost_cnt}, 32'd1);
        check("seq_pkt",  {16'h0, pkt_cnt}, 32'd3);
        check("seq_rx",   {16'h0, rx_seq}, 32'd2);
        check("seq_ts",   rx_timestamp, 32'hA0000003);
        check("seq_drop", {16'h0, drop_cnt}, 32'd0);

        // Overflow: six samples into a four-deep FIFO
        put_hdr(16'h8080, 16'h0003, 32'h00000040, 32'h12345678);
        for (int i = 0; i < 6; i++) put_word(i, {8'(i + 1), 8'(i + 1)});
        send(24, 16'd24);
        check("ovf_level", {29'h0, fifo_level}, 32'd4);
        check("ovf_cnt",   {16'h0, ovf_cnt}, 32'd2);
        rd("ovf_rd0", 16'h0101, 1'b0);
        rd("ovf_rd1", 16'h0202, 1'b0);
        rd("ovf_rd2", 16'h0303, 1'b0);
        rd("ovf_rd3", 16'h0404, 1'b0);
        check("ovf_empty", {29'h0, fifo_level}, 32'd0);

        // Early end inside the payload: one sample kept, held high byte dropped
        put_hdr(16'h8080, 16'h0004, 32'h00000050, 32'h12345678);
        pb[12] = 8'hA1; pb[13] = 8'hB2; pb[14] = 8'hC3;
        send(15, 16'd28);
        check("early_level", {29'h0, fifo_level}, 32'd1);
        check("early_drop",  {16'h0, drop_cnt}, 32'd0);
        rd("early_rd", 16'hA1B2, 1'b0);

        // Odd length: trailing byte ignored; an extra byte past len is discarded
        put_hdr(16'h8080, 16'h0005, 32'h00000060, 32'h12345678);
        pb[12] = 8'h11; pb[13] = 8'h22; pb[14] = 8'h33; pb[15] = 8'h44;
        send(16, 16'd15);
        check("odd_level", {29'h0, fifo_level}, 32'd1);
        check("odd_pkt",   {16'h0, pkt_cnt}, 32'd6);
        check("odd_lost",  {16'h0, lost_cnt}, 32'd1);
        rd("odd_rd0", 16'h1122, 1'b0);
        rd("odd_rd1", 16'h0000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
